// File: rtl/macro_seq_fsm.sv
// Micro-op injection sequencer: emits fixed RTI / INT opcode sequences followed
// by NOP_CYCLES trailing NOP slots, with single-depth pending requests and hold.
module macro_seq_fsm #(
  parameter int                 INSTR_W         = 16,
  parameter int                 NOP_CYCLES      = 4,
  parameter logic [INSTR_W-1:0] POP_PC_LOW_OP   = 16'h6088,
  parameter logic [INSTR_W-1:0] POP_PC_HIGH_OP  = 16'h6089,
  parameter logic [INSTR_W-1:0] POP_CCR_OP      = 16'h608A,
  parameter logic [INSTR_W-1:0] PUSH_CCR_OP     = 16'h508A,
  parameter logic [INSTR_W-1:0] PUSH_PC_HIGH_OP = 16'h5089,
  parameter logic [INSTR_W-1:0] PUSH_PC_LOW_OP  = 16'h5088
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rti,
  input  logic               intr,
  input  logic               hold,
  output logic [INSTR_W-1:0] out,
  output logic               stall,
  output logic               busy,
  output logic               mode,
  output logic               seq_done,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP0  = 3'd1,
    S_OP1  = 3'd2,
    S_OP2  = 3'd3,
    S_NOP  = 3'd4
  } state_t;

  localparam int         NOP_LAST = (NOP_CYCLES > 0) ? NOP_CYCLES - 1 : 0;
  localparam logic [3:0] NOP_LOAD = NOP_LAST[3:0];
  localparam logic       NO_NOP   = (NOP_CYCLES == 0);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic                 pend_int_q, pend_int_d;
  logic                 pend_rti_q, pend_rti_d;
  logic [INSTR_W-1:0]   out_q, out_d;
  logic                 stall_q, stall_d;
  logic                 busy_q, busy_d;
  logic                 seq_done_q, seq_done_d;
  logic                 launch;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    pend_int_d = pend_int_q | intr;
    pend_rti_d = pend_rti_q | rti;
    launch     = 1'b0;

    if (!hold) begin
      case (state_q)
        S_IDLE: launch = 1'b1;
        S_OP0:  state_d = S_OP1;
        S_OP1:  state_d = S_OP2;
        S_OP2: begin
          if (NO_NOP) begin
            launch = 1'b1;
          end else begin
            state_d = S_NOP;
            cnt_d   = NOP_LOAD;
          end
        end
        S_NOP: begin
          if (cnt_q == 4'd0) launch = 1'b1;
          else               cnt_d  = cnt_q - 4'd1;
        end
        default: state_d = S_IDLE;
      endcase

      // Leaving IDLE or the final slot: INT beats RTI, chaining with no idle gap.
      if (launch) begin
        cnt_d = 4'd0;
        if (pend_int_d) begin
          state_d    = S_OP0;
          mode_d     = 1'b1;
          pend_int_d = 1'b0;
        end else if (pend_rti_d) begin
          state_d    = S_OP0;
          mode_d     = 1'b0;
          pend_rti_d = 1'b0;
        end else begin
          state_d = S_IDLE;
          mode_d  = 1'b0;
        end
      end
    end

    out_d      = '0;
    stall_d    = (state_d != S_IDLE);
    busy_d     = (state_d != S_IDLE);
    seq_done_d = 1'b0;
    case (state_d)
      S_OP0: out_d = mode_d ? PUSH_CCR_OP     : POP_PC_LOW_OP;
      S_OP1: out_d = mode_d ? PUSH_PC_HIGH_OP : POP_PC_HIGH_OP;
      S_OP2: begin
        out_d      = mode_d ? PUSH_PC_LOW_OP  : POP_CCR_OP;
        seq_done_d = NO_NOP;
      end
      S_NOP:   seq_done_d = (cnt_d == 4'd0);
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      mode_q     <= 1'b0;
      pend_int_q <= 1'b0;
      pend_rti_q <= 1'b0;
      out_q      <= '0;
      stall_q    <= 1'b0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      pend_int_q <= pend_int_d;
      pend_rti_q <= pend_rti_d;
      out_q      <= out_d;
      stall_q    <= stall_d;
      busy_q     <= busy_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign out       = out_q;
  assign stall     = stall_q;
  assign busy      = busy_q;
  assign mode      = mode_q;
  assign seq_done  = seq_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_macro_seq_fsm.sv
// Bench for macro_seq_fsm: default build (4 NOPs) and a 0-NOP build driven with
// the same stimulus, each checked against a slot-position reference model.
module tb_macro_seq_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic rti   = 1'b0;
  logic intr  = 1'b0;
  logic hold  = 1'b0;

  logic [15:0] out0, out1;
  logic        stall0, stall1, busy0, busy1, mode0, mode1, done0, done1;
  logic [2:0]  dbg0, dbg1;

  macro_seq_fsm u_dut (
    .clk(clk), .reset(reset), .rti(rti), .intr(intr), .hold(hold),
    .out(out0), .stall(stall0), .busy(busy0), .mode(mode0),
    .seq_done(done0), .dbg_state(dbg0)
  );

  macro_seq_fsm #(.NOP_CYCLES(0)) u_dut_nop0 (
    .clk(clk), .reset(reset), .rti(rti), .intr(intr), .hold(hold),
    .out(out1), .stall(stall1), .busy(busy1), .mode(mode1),
    .seq_done(done1), .dbg_state(dbg1)
  );

  logic [19:0] obs [2];
  assign obs[0] = {out0, stall0, busy0, mode0, done0};
  assign obs[1] = {out1, stall1, busy1, mode1, done1};

  int checks = 0;
  int fails  = 0;

  // Reference model: a sequence is a list of 3+N slots; track position in it.
  int nops   [2] = '{4, 0};
  bit m_act  [2] = '{0, 0};
  int m_pos  [2] = '{0, 0};
  bit m_mode [2] = '{0, 0};
  bit m_pi   [2] = '{0, 0};
  bit m_pr   [2] = '{0, 0};

  function automatic logic [15:0] op_of(input bit md, input int pos);
    logic [15:0] rti_ops [3];
    logic [15:0] int_ops [3];
    rti_ops = '{16'h6088, 16'h6089, 16'h608A};
    int_ops = '{16'h508A, 16'h5089, 16'h5088};
    return md ? int_ops[pos] : rti_ops[pos];
  endfunction

  function automatic logic [19:0] exp_vec(input int i);
    logic [15:0] o;
    if (!m_act[i]) return 20'h0;
    o = (m_pos[i] < 3) ? op_of(m_mode[i], m_pos[i]) : 16'h0;
    return {o, 1'b1, 1'b1, m_mode[i], (m_pos[i] == 2 + nops[i])};
  endfunction

  task automatic model_step(input int i, input bit r, input bit ri, input bit in, input bit h);
    if (r) begin
      m_act[i] = 0; m_pos[i] = 0; m_mode[i] = 0; m_pi[i] = 0; m_pr[i] = 0;
      return;
    end
    m_pi[i] = m_pi[i] | in;
    m_pr[i] = m_pr[i] | ri;
    if (h) return;
    if (m_act[i] && m_pos[i] != 2 + nops[i]) begin
      m_pos[i]++;
      return;
    end
    m_pos[i] = 0;
    if (m_pi[i]) begin
      m_act[i] = 1; m_mode[i] = 1; m_pi[i] = 0;
    end else if (m_pr[i]) begin
      m_act[i] = 1; m_mode[i] = 0; m_pr[i] = 0;
    end else begin
      m_act[i] = 0; m_mode[i] = 0;
    end
  endtask

  task automatic tick(input bit r, input bit ri, input bit in, input bit h);
    @(negedge clk);
    reset = r; rti = ri; intr = in; hold = h;
    @(posedge clk);
    model_step(0, r, ri, in, h);
    model_step(1, r, ri, in, h);
    #1;
  endtask

  task automatic test_reset;
    tick(1, 1, 1, 0);
    tick(1, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 20'h0) begin
        fails++;
        $display("FAIL reset dut%0d: got %h want %h", i, obs[i], 20'h0);
      end
    end
  endtask

  task automatic test_rti_basic;
    int st0, dn0, st1, dn1_ccr;
    st0 = 0; dn0 = 0; st1 = 0; dn1_ccr = 0;
    tick(1, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      tick(0, c == 0, 0, 0);
      if (c == 0) begin
        checks++;
        if (out0 !== 16'h6088) begin
          fails++;
          $display("FAIL rti_first_op: got %h want 6088", out0);
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          fails++;
          $display("FAIL rti_basic dut%0d cyc%0d: got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
      st0 += int'(stall0); dn0 += int'(done0); st1 += int'(stall1);
      dn1_ccr += int'(done1 && out1 == 16'h608A);
    end
    checks++;
    if (st0 != 7) begin fails++; $display("FAIL rti_stall_len: got %0d want 7", st0); end
    checks++;
    if (dn0 != 1) begin fails++; $display("FAIL rti_done_count: got %0d want 1", dn0); end
    checks++;
    if (st1 != 3) begin fails++; $display("FAIL nop0_stall_len: got %0d want 3", st1); end
    checks++;
    if (dn1_ccr != 1) begin fails++; $display("FAIL nop0_done_on_608A: got %0d want 1", dn1_ccr); end
  endtask

  task automatic test_back_to_back;
    int st0;
    st0 = 0;
    tick(1, 0, 0, 0);
    for (int c = 0; c < 16; c++) begin
      tick(0, c == 0, c == 0, 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          fails++;
          $display("FAIL back_to_back dut%0d cyc%0d: got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
      if (c < 14) st0 += int'(stall0);
    end
    checks++;
    if (st0 != 14) begin fails++; $display("FAIL b2b_stall_cont: got %0d want 14", st0); end
  endtask

  task automatic test_hold_op1;
    int st0, n6089;
    st0 = 0; n6089 = 0;
    tick(1, 0, 0, 0);
    for (int c = 0; c < 14; c++) begin
      tick(0, c == 0, 0, (c >= 2 && c <= 4));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          fails++;
          $display("FAIL hold_op1 dut%0d cyc%0d: got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
      st0 += int'(stall0); n6089 += int'(out0 == 16'h6089);
    end
    checks++;
    if (n6089 != 4) begin fails++; $display("FAIL hold_op1_len: got %0d want 4", n6089); end
    checks++;
    if (st0 != 10) begin fails++; $display("FAIL hold_stall_len: got %0d want 10", st0); end
  endtask

  task automatic test_hold_final;
    int rises, highs;
    logic prev;
    rises = 0; highs = 0; prev = 1'b0;
    tick(1, 0, 0, 0);
    for (int c = 0; c < 14; c++) begin
      tick(0, c == 0, 0, (c >= 7 && c <= 9));
      checks++;
      if (obs[0] !== exp_vec(0)) begin
        fails++;
        $display("FAIL hold_final cyc%0d: got %h want %h", c, obs[0], exp_vec(0));
      end
      highs += int'(done0);
      rises += int'(done0 && !prev);
      prev = done0;
    end
    checks++;
    if (rises != 1 || highs != 4) begin
      fails++;
      $display("FAIL hold_final_done: got rises=%0d highs=%0d want 1/4", rises, highs);
    end
  endtask

  task automatic test_reset_mid;
    int st0;
    st0 = 0;
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    checks++;
    if (out0 !== 16'h608A) begin fails++; $display("FAIL reset_mid_op2: got %h want 608a", out0); end
    tick(1, 0, 0, 0);
    checks++;
    if (out0 !== 16'h0 || stall0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_abort: got out=%h stall=%b want 0/0", out0, stall0);
    end
    for (int c = 0; c < 12; c++) begin
      tick(0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          fails++;
          $display("FAIL reset_mid dut%0d cyc%0d: got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
      st0 += int'(stall0);
    end
    checks++;
    if (st0 != 0) begin fails++; $display("FAIL reset_no_resume: got %0d stall cycles want 0", st0); end
  endtask

  task automatic test_multi_intr;
    int n_int;
    n_int = 0;
    tick(1, 0, 0, 0);
    for (int c = 0; c < 24; c++) begin
      tick(0, c == 0, (c == 2 || c == 3 || c == 5), 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          fails++;
          $display("FAIL multi_intr dut%0d cyc%0d: got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
      n_int += int'(out0 == 16'h508A);
    end
    checks++;
    if (n_int != 1) begin fails++; $display("FAIL multi_intr_once: got %0d want 1", n_int); end
  endtask

  task automatic test_random;
    bit r, ri, in, h;
    tick(1, 0, 0, 0);
    for (int c = 0; c < 2000; c++) begin
      r  = ($urandom_range(0, 149) == 0);
      ri = ($urandom_range(0, 5) == 0);
      in = ($urandom_range(0, 6) == 0);
      h  = ($urandom_range(0, 3) == 0);
      tick(r, ri, in, h);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          fails++;
          $display("FAIL random dut%0d cyc%0d: got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rti_basic();
    test_back_to_back();
    test_hold_op1();
    test_hold_final();
    test_reset_mid();
    test_multi_intr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
